// File: rtl/softmax_engine.sv
// softmax_engine: sequential, numerically stable softmax over N signed logits with valid/ready on both sides.
// Define SOFTMAX_ARGMAX_EN to add the out_class argmax port.
module softmax_engine #(
    parameter int N         = 10,
    parameter int DW        = 16,
    parameter int FRAC      = 15,
    parameter int ADDR_W    = 10,
    parameter int LUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*DW-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N*DW-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SOFTMAX_ARGMAX_EN
    ,
    output logic [$clog2(N)-1:0] out_class
`endif
);
    localparam int SW = DW + $clog2(N);
    localparam int CW = $clog2(N + 2);
    localparam int IW = $clog2(N);
    localparam logic [2:0] IDLE = 3'd0, MAX = 3'd1, EXP = 3'd2, RECIP = 3'd3, NORM = 3'd4, OUT = 3'd5;
    localparam longint E15 [12] = '{32768, 12055, 4435, 1631, 600, 221, 81, 30, 11, 4, 1, 1};

    // e^-a in Q(FRAC); every entry past 11 rounds to zero
    function automatic logic [DW-1:0] exp_val(input logic [ADDR_W-1:0] a);
        return int'(a) < 12 ? DW'((E15[int'(a)] << FRAC) >> 15) : '0;
    endfunction

    // entry a stands for a sum of a*2^(SW-ADDR_W) LSBs; value is its rounded reciprocal in Q(FRAC)
    function automatic logic [DW-1:0] recip_val(input int a);
        longint r;
        r = (a == 0) ? 0 : ((longint'(1) << (2 * FRAC - SW + ADDR_W)) + longint'(a / 2)) / longint'(a);
        return (a == 0 || r > longint'(2 ** DW - 1)) ? '1 : r[DW-1:0];
    endfunction

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N-1:0][DW-1:0] x_q, exp_q, out_q;
    logic [DW-1:0]        max_q, exp_rd_q, recip_rd_q, recip_q, x_sel;
    logic [SW-1:0]        sum_q;
    logic [IW-1:0]        lane, exp_lane_q, norm_lane_q;
    logic                 exp_vld_q, norm_vld_q, out_valid_q, last_lane, new_max;
    logic [2*DW-1:0]      prod_q, scaled;
    logic [DW:0]          diff, dsh;
    logic [ADDR_W-1:0]    addr;
    logic [DW-1:0]        recip_rom [2**ADDR_W];

    for (genvar g = 0; g < 2 ** ADDR_W; g++) begin : g_rom
        assign recip_rom[g] = recip_val(g);
    end

    assign lane      = cnt_q[IW-1:0];
    assign x_sel     = x_q[lane];
    assign last_lane = cnt_q == CW'(N - 1);
    assign new_max   = cnt_q == '0 || $signed(x_sel) > $signed(max_q);
    assign diff      = {max_q[DW-1], max_q} - {x_sel[DW-1], x_sel};
    assign dsh       = diff >> LUT_SHIFT;
    assign addr      = |(dsh >> ADDR_W) ? '1 : dsh[ADDR_W-1:0];
    assign scaled    = prod_q >> FRAC;
    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? MAX : IDLE;
            MAX:     state_d = last_lane ? EXP : MAX;
            EXP:     state_d = cnt_q == CW'(N) ? RECIP : EXP;
            RECIP:   state_d = cnt_q == CW'(1) ? NORM : RECIP;
            NORM:    state_d = last_lane ? OUT : NORM;
            OUT:     state_d = out_valid_q && out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE || state_q == OUT) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            exp_vld_q   <= 1'b0;
            norm_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_vld_q  <= state_q == EXP && cnt_q < CW'(N);
            norm_vld_q <= state_q == NORM;
            if (state_q == IDLE && in_valid) begin
                x_q   <= in_data;
                sum_q <= '0;
            end
            if (state_q == MAX && new_max) max_q <= x_sel;
            if (state_q == EXP) begin
                exp_rd_q   <= exp_val(addr);
                exp_lane_q <= lane;
            end
            // exp LUT output lands one cycle after its address was issued
            if (exp_vld_q) begin
                exp_q[exp_lane_q] <= exp_rd_q;
                sum_q             <= sum_q + SW'(exp_rd_q);
            end
            if (state_q == RECIP) begin
                recip_rd_q <= recip_rom[sum_q[SW-1 -: ADDR_W]];
                recip_q    <= recip_rd_q;
            end
            if (state_q == NORM) begin
                prod_q      <= exp_q[lane] * recip_q;
                norm_lane_q <= lane;
            end
            if (norm_vld_q) out_q[norm_lane_q] <= |scaled[2*DW-1:DW] ? '1 : scaled[DW-1:0];
            if (state_q == OUT && !out_valid_q) out_valid_q <= 1'b1;
            else if (out_valid_q && out_ready) out_valid_q <= 1'b0;
        end
    end

`ifdef SOFTMAX_ARGMAX_EN
    logic [IW-1:0] idx_q, class_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            class_q <= '0;
        end else begin
            if (state_q == MAX && new_max) idx_q <= lane;
            if (state_q == OUT && !out_valid_q) class_q <= idx_q;
        end
    end
    assign out_class = class_q;
`endif
endmodule

// File: tb/tb_softmax_engine.sv
// tb_softmax_engine: directed vectors with hand-computed probabilities, latency, backpressure and reset checks.
module tb_softmax_engine;
    localparam int N = 10;
    localparam int DW = 16;
    logic            clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [N*DW-1:0] in_data = '0;
    logic            in_ready, out_valid;
    logic [N*DW-1:0] out_data;
`ifdef SOFTMAX_ARGMAX_EN
    logic [$clog2(N)-1:0] out_class;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    softmax_engine dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SOFTMAX_ARGMAX_EN
        , .out_class(out_class)
`endif
    );

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int lane(input int i);
        return int'(out_data[i*DW +: DW]);
    endfunction

    function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] base, input int a, input logic [DW-1:0] va,
                                           input int b, input logic [DW-1:0] vb);
        logic [N*DW-1:0] v;
        v = {N{base}};
        v[a*DW +: DW] = va;
        v[b*DW +: DW] = vb;
        return v;
    endfunction

    // Accept v, scramble in_data afterwards and measure edges until out_valid
    task automatic send(input string tag, input logic [N*DW-1:0] v);
        int lat;
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_accepted"}, int'(in_ready), 0);
        in_valid = 1'b0;
        in_data  = {N{16'h7FFF}};
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 34);
    endtask

    task automatic expect_release(input string tag);
        check({tag, "_in_ready_busy"}, int'(in_ready), 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int rises;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data != '0), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", int'(in_ready), 1);

        send("zero", '0);
        for (int i = 0; i < N; i++) check($sformatf("zero_l%0d", i), lane(i), 3277, 2);
`ifdef SOFTMAX_ARGMAX_EN
        check("zero_class", int'(out_class), 0);
`endif
        expect_release("zero");

        send("peak", mk(16'h0000, 3, 16'h0400, 3, 16'h0400));
        for (int i = 0; i < N; i++) check($sformatf("peak_l%0d", i), lane(i), i == 3 ? 32768 : 0, i == 3 ? 68 : 2);
`ifdef SOFTMAX_ARGMAX_EN
        check("peak_class", int'(out_class), 3);
`endif
        expect_release("peak");

        send("tie", mk(16'hFF00, 2, 16'h0100, 7, 16'h0100));
        for (int i = 0; i < N; i++) check($sformatf("tie_l%0d", i), lane(i), (i == 2 || i == 7) ? 16384 : 0, 2);
`ifdef SOFTMAX_ARGMAX_EN
        check("tie_class", int'(out_class), 2);
`endif
        expect_release("tie");

        out_ready = 1'b0;
        send("bp", mk(16'h0000, 3, 16'h0400, 3, 16'h0400));
        for (int k = 0; k < 20; k++) begin
            in_valid = (k % 3 == 0);
            in_data  = '0;
            @(posedge clk);
            #1;
            check($sformatf("bp_valid_%0d", k), int'(out_valid), 1);
            check($sformatf("bp_in_ready_%0d", k), int'(in_ready), 0);
            check($sformatf("bp_l3_%0d", k), lane(3), 32768, 68);
            check($sformatf("bp_l0_%0d", k), lane(0), 0, 2);
`ifdef SOFTMAX_ARGMAX_EN
            check($sformatf("bp_class_%0d", k), int'(out_class), 3);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_release("bp");
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check("bp_single_handshake", rises, 0);

        @(negedge clk);
        in_data  = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        check("mid_not_done", int'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_data", int'(out_data != '0), 0);
        check("mrst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_rel_in_ready", int'(in_ready), 1);
        rises = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check("mrst_no_stale", rises, 0);

        send("again", '0);
        check("again_l0", lane(0), 3277, 2);
        check("again_l9", lane(9), 3277, 2);
        expect_release("again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
